// File: rtl/ahb_bridge_arbiter.sv
// Round-robin arbiter for the shared AHB-to-APB bridge port with a per-tenure burst cap.
// Optional locked transfers are enabled by defining ARB_LOCK_EN.
`default_nettype none

module ahb_bridge_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_BURST      = 16
) (
  input  logic                                 hclk,
  input  logic                                 hresetn,
  input  logic [NUM_MASTERS-1:0]               hbusreq,
  input  logic [NUM_MASTERS-1:0]               hlock,
  input  logic [1:0]                           htrans,
  input  logic                                 hready,
  output logic [NUM_MASTERS-1:0]               hgrant,
  output logic [$clog2(NUM_MASTERS)-1:0]       hmaster,
  output logic [$clog2(NUM_MASTERS)-1:0]       hmaster_d,
  output logic                                 hmastlock
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = $clog2(MAX_BURST + 1);

  localparam logic [1:0] ST_PARK   = 2'd0;
  localparam logic [1:0] ST_OWN    = 2'd1;
`ifdef ARB_LOCK_EN
  localparam logic [1:0] ST_LOCKED = 2'd2;
`endif

  localparam logic [IW-1:0] DEF_IDX = IW'(DEFAULT_MASTER);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] hmaster_q, hmaster_d_q;
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [CW-1:0] cnt_sat;
  logic          expire;
  logic          lock_req;

  // Only HTRANS[1] (NONSEQ/SEQ) matters; hlock is dead without the lock feature.
  logic w_unused_inputs;
  assign w_unused_inputs = htrans[0] ^ (^hlock);

`ifdef ARB_LOCK_EN
  assign lock_req = hlock[gidx_q];
`else
  assign lock_req = 1'b0;
`endif

  // Descending scan so the nearest requester after rr_ptr is the last to overwrite.
  always_comb begin
    logic [IW-1:0] idx;
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    idx       = '0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      idx = IW'((int'(rr_ptr_q) + i) % NUM_MASTERS);
      if (hbusreq[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  assign cnt_sat = (htrans[1] && (cnt_q != MAX_CNT)) ? cnt_q + CW'(1) : cnt_q;
  assign expire  = (cnt_sat == MAX_CNT);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= ST_PARK;
      gidx_q      <= DEF_IDX;
      rr_ptr_q    <= DEF_IDX;
      cnt_q       <= '0;
      hmaster_q   <= DEF_IDX;
      hmaster_d_q <= DEF_IDX;
    end else if (hready) begin
      state_q     <= state_d;
      gidx_q      <= gidx_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      hmaster_q   <= gidx_q;
      hmaster_d_q <= hmaster_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    gidx_d   = gidx_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_sat;
    case (state_q)
      ST_PARK: begin
        cnt_d = '0;
        if (win_found) begin
          state_d  = ST_OWN;
          gidx_d   = win_idx;
          rr_ptr_d = win_idx;
        end
      end
      ST_OWN: begin
        if (lock_req) begin
`ifdef ARB_LOCK_EN
          state_d = ST_LOCKED;
`endif
        end else if (hbusreq[gidx_q] && !expire) begin
          state_d = ST_OWN;
        end else if (win_found) begin
          gidx_d   = win_idx;
          rr_ptr_d = win_idx;
          cnt_d    = '0;
        end else begin
          state_d = ST_PARK;
          gidx_d  = DEF_IDX;
          cnt_d   = '0;
        end
      end
`ifdef ARB_LOCK_EN
      // The beat on which hlock drops is still owned; normal rules resume next edge.
      ST_LOCKED: begin
        if (!lock_req) state_d = ST_OWN;
      end
`endif
      default: begin
        state_d = ST_PARK;
        gidx_d  = DEF_IDX;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef ARB_LOCK_EN
  logic hmastlock_q;
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      hmastlock_q <= 1'b0;
    end else if (hready) begin
      hmastlock_q <= lock_req && (state_q != ST_PARK);
    end
  end
  assign hmastlock = hmastlock_q;
`else
  assign hmastlock = 1'b0;
`endif

  always_comb begin
    hgrant         = '0;
    hgrant[gidx_q] = 1'b1;
  end

  assign hmaster   = hmaster_q;
  assign hmaster_d = hmaster_d_q;

endmodule

`default_nettype wire
